simon_sequence_ctrl: RTL and testbench

//  Round sequencer for the Simon game. Each round it appends one random colour
//  to a stored sequence, plays the whole sequence back as timed presses, and

---
 rtl/simon_sequence_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_simon_sequence_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/simon_sequence_ctrl.sv
// Simon round sequencer: grows a random colour sequence, plays it back as timed
// presses, then checks the player's presses against it until a mistake, timeout or win.
module simon_sequence_ctrl #(
    parameter int MAX_LEN       = 16,
    parameter int LEN_W         = 5,
    parameter int ON_TICKS      = 30,
    parameter int OFF_TICKS     = 15,
    parameter int TIMEOUT_TICKS = 300
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic [1:0]       rand_num,
    input  logic [1:0]       player_num,
    input  logic             player_pressed,
    output logic             simon_turn,
    output logic [1:0]       simon_num,
    output logic             simon_pressed,
    output logic             game_over,
    output logic             win,
    output logic [LEN_W-1:0] score
);

    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TIMER_W = $clog2(ON_TICKS + OFF_TICKS + TIMEOUT_TICKS + 1);

    typedef enum logic [2:0] {
        ADD       = 3'd0,
        PLAY_ON   = 3'd1,
        PLAY_OFF  = 3'd2,
        PLAY_WAIT = 3'd3,
        WAIT_REL  = 3'd4,
        OVER      = 3'd5,
        WIN       = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   idx_q, idx_d;
    logic [LEN_W-1:0]   score_q, score_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               press_q;
    logic [1:0]         seq_q [MAX_LEN];

    logic       press_edge;
    logic       last_idx;
    logic [1:0] cur_colour;

    assign press_edge = player_pressed & ~press_q;
    assign last_idx   = (idx_q == len_q - LEN_W'(1));
    assign cur_colour = seq_q[idx_q[IDX_W-1:0]];

    // Sequence storage is never reset; entry len is always written in ADD before it is read.
    always_ff @(posedge clk) begin
        if (state_q == ADD) begin
            seq_q[len_q[IDX_W-1:0]] <= rand_num;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ADD;
            len_q   <= '0;
            idx_q   <= '0;
            score_q <= '0;
            timer_q <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            score_q <= score_d;
            timer_q <= timer_d;
            press_q <= player_pressed;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        score_d = score_q;
        timer_d = timer_q;
        case (state_q)
            ADD: begin
                len_d   = len_q + LEN_W'(1);
                idx_d   = '0;
                timer_d = '0;
                state_d = PLAY_ON;
            end
            PLAY_ON: begin
                if (step_en) begin
                    if (timer_q == TIMER_W'(ON_TICKS - 1)) begin
                        timer_d = '0;
                        state_d = PLAY_OFF;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            PLAY_OFF: begin
                if (step_en) begin
                    if (timer_q == TIMER_W'(OFF_TICKS - 1)) begin
                        timer_d = '0;
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = PLAY_WAIT;
                        end else begin
                            idx_d   = idx_q + LEN_W'(1);
                            state_d = PLAY_ON;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            PLAY_WAIT: begin
                // A press in the same clk as a timer tick takes priority over the timeout.
                if (press_edge) begin
                    if (player_num == cur_colour) begin
                        timer_d = '0;
                        state_d = WAIT_REL;
                    end else begin
                        state_d = OVER;
                    end
                end else if (step_en) begin
                    if (timer_q == TIMER_W'(TIMEOUT_TICKS - 1)) begin
                        state_d = OVER;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            WAIT_REL: begin
                if (!player_pressed) begin
                    if (last_idx) begin
                        score_d = score_q + LEN_W'(1);
                        state_d = (len_q == LEN_W'(MAX_LEN)) ? WIN : ADD;
                    end else begin
                        idx_d   = idx_q + LEN_W'(1);
                        timer_d = '0;
                        state_d = PLAY_WAIT;
                    end
                end
            end
            OVER:    state_d = OVER;
            WIN:     state_d = WIN;
            default: state_d = OVER;
        endcase
    end

    always_comb begin
        simon_turn    = 1'b0;
        simon_num     = 2'd0;
        simon_pressed = 1'b0;
        game_over     = 1'b0;
        win           = 1'b0;
        case (state_q)
            ADD:      simon_turn = 1'b1;
            PLAY_ON: begin
                simon_turn    = 1'b1;
                simon_num     = cur_colour;
                simon_pressed = 1'b1;
            end
            PLAY_OFF: begin
                simon_turn = 1'b1;
                simon_num  = cur_colour;
            end
            OVER:     game_over = 1'b1;
            WIN: begin
                game_over = 1'b1;
                win       = 1'b1;
            end
            default: ;
        endcase
    end

    assign score = score_q;

endmodule

// File: tb/tb_simon_sequence_ctrl.sv
// Directed bench for simon_sequence_ctrl built with a four-round game so the
// win path is reachable; step_en is pulsed on every other clock.
module tb_simon_sequence_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       step_en = 1'b0;
    logic [1:0] rand_num = 2'd0;
    logic [1:0] player_num = 2'd0;
    logic       player_pressed = 1'b0;
    logic       simon_turn;
    logic [1:0] simon_num;
    logic       simon_pressed;
    logic       game_over;
    logic       win;
    logic [2:0] score;

    int errs = 0;
    int checks = 0;
    logic [1:0] exp_seq [0:3];

    simon_sequence_ctrl #(
        .MAX_LEN(4),
        .LEN_W(3),
        .ON_TICKS(30),
        .OFF_TICKS(15),
        .TIMEOUT_TICKS(300)
    ) dut (
        .clk(clk),
        .reset(reset),
        .step_en(step_en),
        .rand_num(rand_num),
        .player_num(player_num),
        .player_pressed(player_pressed),
        .simon_turn(simon_turn),
        .simon_num(simon_num),
        .simon_pressed(simon_pressed),
        .game_over(game_over),
        .win(win),
        .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic clk1(input logic se);
        step_en = se;
        @(posedge clk);
        #1;
        step_en = 1'b0;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            clk1(1'b0);
            clk1(1'b1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_turn"}, 32'(simon_turn), 32'd1);
        chk({tag, "_num"}, 32'(simon_num), 32'd0);
        chk({tag, "_pressed"}, 32'(simon_pressed), 32'd0);
        chk({tag, "_over"}, 32'(game_over), 32'd0);
        chk({tag, "_win"}, 32'(win), 32'd0);
        chk({tag, "_score"}, 32'(score), 32'd0);
    endtask

    // Asserts reset between clock edges so the outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        clk1(1'b0);
        reset = 1'b0;
        $display("reset %s done", tag);
    endtask

    // Starts in ADD and checks a full playback of exp_seq[0..len-1].
    task automatic play_seq(input int len);
        int n;
        chk("add_turn", 32'(simon_turn), 32'd1);
        chk("add_pressed", 32'(simon_pressed), 32'd0);
        clk1(1'b0);
        for (int i = 0; i < len; i++) begin
            chk("on_num_start", 32'(simon_num), 32'(exp_seq[i]));
            n = 0;
            while (simon_pressed && n < 100) begin
                tick_n(1);
                n++;
            end
            chk("on_ticks", 32'(n), 32'd30);
            chk("off_num_hold", 32'(simon_num), 32'(exp_seq[i]));
            n = 0;
            while (simon_turn && !simon_pressed && n < 100) begin
                tick_n(1);
                n++;
            end
            chk("off_ticks", 32'(n), 32'd15);
        end
        chk("wait_turn", 32'(simon_turn), 32'd0);
        chk("wait_pressed", 32'(simon_pressed), 32'd0);
        $display("playback len=%0d finished", len);
    endtask

    task automatic press(input logic [1:0] col, input logic se);
        player_num = col;
        player_pressed = 1'b1;
        clk1(se);
        $display("press colour=%0d step_en=%0d game_over=%0d", col, se, game_over);
    endtask

    task automatic release_btn();
        player_pressed = 1'b0;
        clk1(1'b0);
        $display("release score=%0d turn=%0d", score, simon_turn);
    endtask

    initial begin
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First round: colour 2 shown for 30 ticks, then 15 off.
        rand_num = 2'd2;
        exp_seq[0] = 2'd2;
        play_seq(1);

        // Correct press completes round 1, then a two-entry playback.
        press(2'd2, 1'b0);
        chk("r1_press_ok", 32'(game_over), 32'd0);
        release_btn();
        chk("r1_score", 32'(score), 32'd1);
        rand_num = 2'd3;
        exp_seq[1] = 2'd3;
        play_seq(2);

        // Timeout boundary: a press after 299 ticks, landing on a tick, is accepted.
        tick_n(299);
        chk("to_299_alive", 32'(game_over), 32'd0);
        press(2'd2, 1'b1);
        chk("to_press_wins", 32'(game_over), 32'd0);
        release_btn();
        chk("to_next_wait", 32'(simon_turn), 32'd0);
        tick_n(299);
        chk("to_299_again", 32'(game_over), 32'd0);
        tick_n(1);
        chk("to_over", 32'(game_over), 32'd1);
        chk("to_win", 32'(win), 32'd0);
        chk("to_score", 32'(score), 32'd1);

        // Wrong colour ends the game; later presses are ignored.
        do_reset("rst_mismatch");
        rand_num = 2'd3;
        exp_seq[0] = 2'd3;
        play_seq(1);
        press(2'd1, 1'b0);
        chk("mm_over", 32'(game_over), 32'd1);
        chk("mm_win", 32'(win), 32'd0);
        release_btn();
        press(2'd3, 1'b0);
        release_btn();
        tick_n(3);
        chk("mm_sticky", 32'(game_over), 32'd1);
        chk("mm_score", 32'(score), 32'd0);
        chk("mm_turn", 32'(simon_turn), 32'd0);

        // Button held from playback into the player's turn is not a press.
        do_reset("rst_held");
        rand_num = 2'd1;
        exp_seq[0] = 2'd1;
        player_num = 2'd2;
        player_pressed = 1'b1;
        play_seq(1);
        tick_n(5);
        chk("held_no_compare", 32'(game_over), 32'd0);
        release_btn();
        chk("held_release", 32'(game_over), 32'd0);
        press(2'd1, 1'b0);
        chk("held_repress_ok", 32'(game_over), 32'd0);
        release_btn();
        chk("held_score", 32'(score), 32'd1);

        // Reset in the middle of PLAY_ON, then the first colour is redrawn.
        rand_num = 2'd2;
        clk1(1'b0);
        tick_n(5);
        chk("mid_on_pressed", 32'(simon_pressed), 32'd1);
        do_reset("rst_mid_on");
        rand_num = 2'd3;
        exp_seq[0] = 2'd3;
        play_seq(1);
        chk("redraw_score", 32'(score), 32'd0);

        // Four correct rounds reach the win state.
        do_reset("rst_win");
        exp_seq[0] = 2'd1;
        exp_seq[1] = 2'd2;
        exp_seq[2] = 2'd3;
        exp_seq[3] = 2'd0;
        for (int r = 0; r < 4; r++) begin
            rand_num = exp_seq[r];
            play_seq(r + 1);
            for (int i = 0; i <= r; i++) begin
                press(exp_seq[i], 1'b0);
                release_btn();
            end
            chk("win_round_score", 32'(score), 32'(r + 1));
            if (r < 3) begin
                chk("win_round_add", 32'(simon_turn), 32'd1);
            end else begin
                chk("win_flag", 32'(win), 32'd1);
                chk("win_over", 32'(game_over), 32'd1);
            end
        end
        tick_n(20);
        chk("win_no_add", 32'(simon_turn), 32'd0);
        chk("win_sticky", 32'(win), 32'd1);
        chk("win_score_final", 32'(score), 32'd4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
